// File: rtl/stream_mux_n_to_1.sv
// stream_mux_n_to_1: NUM_CH:1 valid/ready stream multiplexer with a one-entry
// registered output stage. mode=0 selects the channel given by sel; mode=1
// arbitrates round-robin among the valid channels.
// Optional feature macro: MUX_PARITY_EN adds a registered out_parity output.
module stream_mux_n_to_1 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
`ifdef MUX_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  // Output stage state
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_ch;
  logic [SEL_W-1:0]  r_rr_ptr;   // last channel granted in round-robin mode

  // Per-channel unpacked view of the flat data bus
  logic [DATA_W-1:0] w_ch_data [NUM_CH];

  // Fixed-select match: at most one bit set, none when sel >= NUM_CH
  logic [NUM_CH-1:0] w_fix_hit;

  // Round-robin search split in two halves: channels above rr_ptr first,
  // then wrap around to the lowest valid channel overall.
  logic [NUM_CH-1:0] w_hi_mask;
  logic [NUM_CH-1:0] w_hi_req;
  logic [NUM_CH:0]   w_hi_seen;
  logic [NUM_CH:0]   w_all_seen;
  logic [NUM_CH-1:0] w_hi_first;
  logic [NUM_CH-1:0] w_all_first;
  logic [SEL_W-1:0]  w_hi_idx  [NUM_CH+1];
  logic [SEL_W-1:0]  w_all_idx [NUM_CH+1];

  logic [NUM_CH-1:0] w_rr_onehot;
  logic [SEL_W-1:0]  w_rr_ch;
  logic [NUM_CH-1:0] w_gnt_onehot;
  logic [SEL_W-1:0]  w_gnt_ch;
  logic              w_grant;
  logic              w_load_en;
  logic              w_xfer;

  assign w_hi_seen[0]  = 1'b0;
  assign w_all_seen[0] = 1'b0;
  assign w_hi_idx[0]   = '0;
  assign w_all_idx[0]  = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
      assign w_fix_hit[gi] = in_valid[gi] && (sel == SEL_W'(gi));

      // Priority chains: first valid channel strictly above rr_ptr, and
      // first valid channel from index 0 (used when the upper half is empty).
      assign w_hi_mask[gi]    = (SEL_W'(gi) > r_rr_ptr);
      assign w_hi_req[gi]     = in_valid[gi] & w_hi_mask[gi];
      assign w_hi_first[gi]   = w_hi_req[gi] & ~w_hi_seen[gi];
      assign w_all_first[gi]  = in_valid[gi] & ~w_all_seen[gi];
      assign w_hi_seen[gi+1]  = w_hi_seen[gi] | w_hi_req[gi];
      assign w_all_seen[gi+1] = w_all_seen[gi] | in_valid[gi];
      assign w_hi_idx[gi+1]   = w_hi_idx[gi]  | (w_hi_first[gi]  ? SEL_W'(gi) : '0);
      assign w_all_idx[gi+1]  = w_all_idx[gi] | (w_all_first[gi] ? SEL_W'(gi) : '0);
    end
  endgenerate

  // Select the granted channel for the current mode
  always_comb begin
    w_rr_onehot  = w_hi_seen[NUM_CH] ? w_hi_first : w_all_first;
    w_rr_ch      = w_hi_seen[NUM_CH] ? w_hi_idx[NUM_CH] : w_all_idx[NUM_CH];
    if (mode) begin
      w_gnt_onehot = w_rr_onehot;
      w_gnt_ch     = w_rr_ch;
      w_grant      = w_all_seen[NUM_CH];
    end else begin
      w_gnt_onehot = w_fix_hit;
      w_gnt_ch     = sel;
      w_grant      = |w_fix_hit;
    end
  end

  // The output register can take a word when empty or being drained this cycle
  assign w_load_en = ~r_valid | out_ready;
  assign w_xfer    = w_grant & w_load_en & ~rst;
  assign in_ready  = (w_load_en && !rst) ? w_gnt_onehot : '0;

  // Output register and round-robin pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ch     <= '0;
      r_rr_ptr <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_ch_data[w_gnt_ch];
      r_ch    <= w_gnt_ch;
      if (mode) begin
        r_rr_ptr <= w_gnt_ch;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  logic r_parity;

  // Parity is captured alongside the data word so it never lags out_data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= ^w_ch_data[w_gnt_ch];
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// tb_stream_mux_n_to_1: directed bench for stream_mux_n_to_1. Expected output
// words are queued as stimulus is issued; a negedge monitor pops and compares
// each accepted output word. A second 6-channel instance covers out-of-range sel.
// Define MUX_PARITY_EN to also exercise out_parity.
module tb_stream_mux_n_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ch;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [7:0]  out_data6;
  logic        out_valid6;
  logic        out_ready6;
  logic [2:0]  out_ch6;

`ifdef MUX_PARITY_EN
  logic out_parity;
  logic out_parity6;
`endif

  stream_mux_n_to_1 #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  stream_mux_n_to_1 #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data6),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .mode      (mode6),
    .sel       (sel6),
    .out_data  (out_data6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .out_ch    (out_ch6)
`ifdef MUX_PARITY_EN
    ,
    .out_parity(out_parity6)
`endif
  );

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_exp(input logic [2:0] ch, input logic [7:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_unexpected: got ch=%0d data=%02h, required no word", out_ch, out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_ch !== e.ch || out_data !== e.data) begin
          n_fail++;
          $display("FAIL mon_word: got ch=%0d data=%02h, required ch=%0d data=%02h",
                   out_ch, out_data, e.ch, e.data);
        end else begin
          $display("[TB] word ch=%0d data=%02h", out_ch, out_data);
        end
`ifdef MUX_PARITY_EN
        n_tests++;
        if (out_parity !== ^e.data) begin
          n_fail++;
          $display("FAIL mon_parity: got %0b, required %0b", out_parity, ^e.data);
        end
`endif
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rr_seq [6];
    logic [2:0] ms_seq [3];
    rr_seq = '{3'd1, 3'd3, 3'd7, 3'd1, 3'd3, 3'd7};
    ms_seq = '{3'd5, 3'd0, 3'd1};

    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 6; k++) in_data6[k*8 +: 8] = 8'h60 + 8'(k);
    rst = 1'b1; in_valid = 8'hFF; mode = 1'b0; sel = 3'd5; out_ready = 1'b1;
    in_valid6 = '0; mode6 = 1'b0; sel6 = 3'd0; out_ready6 = 1'b1;

    // Reset: two cycles with all channels valid
    @(negedge clk);
    chk("rst_in_ready0", in_ready, 8'h00);
    cyc();
    @(negedge clk);
    chk("rst_in_ready1", in_ready, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_ch", out_ch, 3'd0);
`ifdef MUX_PARITY_EN
    chk("rst_parity", out_parity, 1'b0);
`endif
    cyc();
    rst = 1'b0;

    // Fixed mode, sel=5
    for (int i = 0; i < 3; i++) begin
      push_exp(3'd5, 8'hA5);
      @(negedge clk);
      chk("fix_in_ready", in_ready, 8'h20);
      if (i > 0) begin
        chk("fix_out_valid", out_valid, 1'b1);
        chk("fix_out_data", out_data, 8'hA5);
      end
      cyc();
    end

    // Round-robin over channels 1,3,7
    mode = 1'b1; in_valid = 8'b1000_1010;
    for (int i = 0; i < 6; i++) begin
      push_exp(rr_seq[i], 8'hA0 + 8'(rr_seq[i]));
      @(negedge clk);
      chk("rr_in_ready", in_ready, 8'h01 << rr_seq[i]);
      cyc();
    end
    in_valid = 8'h00;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 8'h00);
    cyc();

    // Backpressure: load ch2, stall 4 cycles with ch4 waiting
    in_valid = 8'h04; out_ready = 1'b0;
    push_exp(3'd2, 8'hA2);
    @(negedge clk);
    chk("bp_load_ready", in_ready, 8'h04);
    cyc();
    in_valid = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 8'h00);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, 8'hA2);
      chk("bp_out_ch", out_ch, 3'd2);
      cyc();
    end
    out_ready = 1'b1;
    push_exp(3'd4, 8'hA4);
    @(negedge clk);
    chk("bp_release_ready", in_ready, 8'h10);
    cyc();
    in_valid = 8'h00;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_ch", out_ch, 3'd4);
    cyc();

    // Fixed grant does not move the pointer; round-robin resumes after ch4
    mode = 1'b0; sel = 3'd1; in_valid = 8'h02;
    push_exp(3'd1, 8'hA1);
    @(negedge clk);
    chk("ms_fix_ready", in_ready, 8'h02);
    cyc();
    mode = 1'b1; in_valid = 8'b0010_0011;
    for (int i = 0; i < 3; i++) begin
      push_exp(ms_seq[i], 8'hA0 + 8'(ms_seq[i]));
      @(negedge clk);
      chk("ms_rr_ready", in_ready, 8'h01 << ms_seq[i]);
      cyc();
    end

    // Single valid channel: granted every cycle
    in_valid = 8'h08;
    for (int i = 0; i < 3; i++) begin
      push_exp(3'd3, 8'hA3);
      @(negedge clk);
      chk("single_ready", in_ready, 8'h08);
      cyc();
    end
    in_valid = 8'h00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("idle_out_valid", out_valid, 1'b0);
    cyc();

    // Out-of-range select on the 6-channel instance
    mode6 = 1'b0; sel6 = 3'd2; in_valid6 = 6'h3F; out_ready6 = 1'b0;
    @(negedge clk);
    chk("s6_in_ready", in_ready6, 6'h04);
    cyc();
    sel6 = 3'd7;
    @(negedge clk);
    chk("s6_bad_ready", in_ready6, 6'h00);
    chk("s6_held_valid", out_valid6, 1'b1);
    chk("s6_held_data", out_data6, 8'h62);
    chk("s6_held_ch", out_ch6, 3'd2);
    cyc();
    out_ready6 = 1'b1;
    @(negedge clk);
    chk("s6_drain_ready", in_ready6, 6'h00);
    chk("s6_drain_valid", out_valid6, 1'b1);
    cyc();
    sel6 = 3'd6;
    @(negedge clk);
    chk("s6_fall_valid", out_valid6, 1'b0);
    chk("s6_sel6_ready", in_ready6, 6'h00);
    cyc();
    in_valid6 = 6'h00;

    // Parity words 07 then 03 on ch0
    mode = 1'b0; sel = 3'd0; in_valid = 8'h01; in_data[7:0] = 8'h07;
    push_exp(3'd0, 8'h07);
    @(negedge clk);
    cyc();
    in_data[7:0] = 8'h03;
    push_exp(3'd0, 8'h03);
    @(negedge clk);
`ifdef MUX_PARITY_EN
    chk("par_07", out_parity, 1'b1);
`endif
    cyc();
    in_valid = 8'h00;
    @(negedge clk);
`ifdef MUX_PARITY_EN
    chk("par_03", out_parity, 1'b0);
`endif
    chk("par_data", out_data, 8'h03);
    cyc();
    in_data[7:0] = 8'hA0;

    // Reset while a word is held: word discarded, pointer back to NUM_CH-1
    mode = 1'b1; in_valid = 8'h40; out_ready = 1'b0;
    @(negedge clk);
    chk("rm_load_ready", in_ready, 8'h40);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_ready", in_ready, 8'h00);
    cyc();
    rst = 1'b0; in_valid = 8'h00;
    @(negedge clk);
    chk("rm_out_valid", out_valid, 1'b0);
    chk("rm_out_data", out_data, 8'h00);
    chk("rm_out_ch", out_ch, 3'd0);
    cyc();
    in_valid = 8'b1000_0001; out_ready = 1'b1;
    push_exp(3'd0, 8'hA0);
    @(negedge clk);
    chk("rm_rr_start", in_ready, 8'h01);
    cyc();
    in_valid = 8'h00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
